// File: rtl/instr_fetch.sv
// Instruction fetch unit: requests one word at pc, holds it for decode until retire,
// then advances pc by sequential, branch or jump rules. A stalled memory ends in a sticky error.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic        jump,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_err
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, ERR} state_t;

    // A miss in the REQ cycle whose counter already holds TIMEOUT-1 is the TIMEOUT-th miss.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] instr_reg, instr_next;
    logic [15:0] wait_reg, wait_next;
    logic [31:0] branch_target, jump_target;

    assign pc_plus4      = pc_reg + 32'd4;
    assign branch_target = pc_plus4 + {{14{instr_reg[15]}}, instr_reg[15:0], 2'b00};
    assign jump_target   = {pc_plus4[31:28], instr_reg[25:0], 2'b00};

    assign imem_req    = (state_reg == REQ);
    assign imem_addr   = pc_reg;
    assign instr_valid = (state_reg == HOLD);
    assign fetch_err   = (state_reg == ERR);
    assign pc          = pc_reg;
    assign instr       = instr_reg;

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        instr_next = instr_reg;
        wait_next  = wait_reg;
        case (state_reg)
            IDLE: begin
                state_next = REQ;
                wait_next  = '0;
            end
            REQ: begin
                if (imem_valid) begin
                    instr_next = imem_rdata;
                    state_next = HOLD;
                end else begin
                    wait_next = wait_reg + 16'd1;
                    if (wait_reg == WAIT_LAST) begin
                        state_next = ERR;
                    end
                end
            end
            HOLD: begin
                if (!stall) begin
                    if (jump) begin
                        pc_next = jump_target;
                    end else if (branch_taken) begin
                        pc_next = branch_target;
                    end else begin
                        pc_next = pc_plus4;
                    end
                    state_next = REQ;
                    wait_next  = '0;
                end
            end
            ERR: begin
                state_next = ERR;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            pc_reg    <= RESET_PC;
            instr_reg <= '0;
            wait_reg  <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            instr_reg <= instr_next;
            wait_reg  <= wait_next;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level model of the fetch loop.
module tb_instr_fetch;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic        jump = 1'b0;
    logic        imem_req, instr_valid, fetch_err;
    logic [31:0] imem_addr, instr, pc, pc_plus4;

    instr_fetch #(.RESET_PC(32'h0000_0000), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .stall(stall), .branch_taken(branch_taken), .jump(jump),
        .instr(instr), .instr_valid(instr_valid),
        .pc(pc), .pc_plus4(pc_plus4), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endtask

    // Model: what the fetch loop is doing (waiting to start, fetching, holding, dead).
    localparam int M_START = 0, M_FETCH = 1, M_HOLD = 2, M_DEAD = 3;
    int          m_mode  = M_START;
    int          m_miss  = 0;
    logic [31:0] m_pc    = 32'h0;
    logic [31:0] m_instr = 32'h0;

    function automatic logic [31:0] model_next_pc(input logic [31:0] p, input logic [31:0] ins,
                                                  input logic j, input logic b);
        logic [31:0] p4;
        int          off;
        p4  = p + 32'd4;
        off = int'($signed(ins[15:0]));
        if (j) return (p4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
        if (b) return p4 + 32'(off * 4);
        return p4;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode  <= M_START;
            m_miss  <= 0;
            m_pc    <= 32'h0;
            m_instr <= 32'h0;
        end else begin
            if (m_mode == M_START) begin
                m_mode <= M_FETCH;
                m_miss <= 0;
            end else if (m_mode == M_FETCH) begin
                if (imem_valid) begin
                    m_instr <= imem_rdata;
                    m_mode  <= M_HOLD;
                end else begin
                    m_miss <= m_miss + 1;
                    if (m_miss + 1 >= TMO) m_mode <= M_DEAD;
                end
            end else if (m_mode == M_HOLD && !stall) begin
                m_pc   <= model_next_pc(m_pc, m_instr, jump, branch_taken);
                m_mode <= M_FETCH;
                m_miss <= 0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        chkb("m_imem_req", imem_req, m_mode == M_FETCH);
        chk("m_imem_addr", imem_addr, m_pc);
        chk("m_pc", pc, m_pc);
        chk("m_pc_plus4", pc_plus4, m_pc + 32'd4);
        chkb("m_instr_valid", instr_valid, m_mode == M_HOLD);
        chk("m_instr", instr, m_instr);
        chkb("m_fetch_err", fetch_err, m_mode == M_DEAD);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        imem_valid = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; imem_rdata = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        tick(); tick();
        chk("rst_pc", pc, 32'h0);
        chk("rst_pc_plus4", pc_plus4, 32'h4);
        chkb("rst_imem_req", imem_req, 1'b0);
        chkb("rst_instr_valid", instr_valid, 1'b0);
        chkb("rst_fetch_err", fetch_err, 1'b0);
        chk("rst_instr", instr, 32'h0);
        $display("[TB] reset state checked");

        // Sequential stream, single-cycle memory
        do_reset();
        imem_valid = 1'b1; imem_rdata = 32'h2000_0001;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k % 2 == 1) begin
                chkb("seq_req", imem_req, 1'b1);
                chk("seq_addr", imem_addr, 32'(4 * ((k - 1) / 2)));
                chkb("seq_ivalid_lo", instr_valid, 1'b0);
            end else begin
                chkb("seq_ivalid_hi", instr_valid, 1'b1);
                chkb("seq_req_lo", imem_req, 1'b0);
            end
        end
        $display("[TB] sequential fetch 0x0,0x4,0x8 done");

        // Stall held three cycles in HOLD at pc 0x4
        do_reset();
        imem_valid = 1'b1; imem_rdata = 32'h1111_0000;
        tick(); tick(); tick();
        imem_rdata = 32'hABCD_1234; stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_instr", instr, 32'hABCD_1234);
            chk("stall_pc", pc, 32'h4);
            chkb("stall_ivalid", instr_valid, 1'b1);
            chkb("stall_req", imem_req, 1'b0);
        end
        stall = 1'b0;
        tick();
        chkb("unstall_req", imem_req, 1'b1);
        chk("unstall_addr", imem_addr, 32'h8);
        $display("[TB] stall hold done");

        // Jump beats branch
        do_reset();
        imem_valid = 1'b1; imem_rdata = 32'h0800_0010;
        tick(); tick();
        jump = 1'b1; branch_taken = 1'b1;
        tick();
        jump = 1'b0; branch_taken = 1'b0;
        chkb("jump_req", imem_req, 1'b1);
        chk("jump_addr", imem_addr, 32'h40);
        $display("[TB] jump priority done");

        // Branch with imm16 = -1 at pc 0x8, taken then not taken
        do_reset();
        imem_valid = 1'b1; imem_rdata = 32'h0;
        tick(); tick(); tick(); tick(); tick();
        imem_rdata = 32'h1000_FFFF;
        tick();
        branch_taken = 1'b1;
        tick();
        branch_taken = 1'b0;
        chk("br_taken_addr", imem_addr, 32'h8);
        tick(); tick();
        chk("br_not_taken_addr", imem_addr, 32'hC);
        $display("[TB] branch taken/not-taken done");

        // Backward branch to 0xFFFFFFFC, then sequential wrap to 0
        do_reset();
        imem_valid = 1'b1; imem_rdata = 32'h1000_FFFE;
        tick(); tick();
        branch_taken = 1'b1;
        tick();
        branch_taken = 1'b0; imem_rdata = 32'h0;
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        chk("wrap_pc_plus4", pc_plus4, 32'h0);
        tick(); tick();
        chk("wrap_next_addr", imem_addr, 32'h0);
        $display("[TB] pc wrap done");

        // Timeout with no response
        do_reset();
        imem_valid = 1'b0;
        tick(); tick(); tick(); tick();
        chkb("tmo_req_4th", imem_req, 1'b1);
        chkb("tmo_err_4th", fetch_err, 1'b0);
        tick();
        chkb("tmo_err", fetch_err, 1'b1);
        chkb("tmo_req_lo", imem_req, 1'b0);
        imem_valid = 1'b1;
        tick(); tick();
        chkb("tmo_err_sticky", fetch_err, 1'b1);
        chkb("tmo_ivalid", instr_valid, 1'b0);
        chk("tmo_pc", pc, 32'h0);
        // Response on the 4th REQ cycle wins
        do_reset();
        imem_valid = 1'b0;
        tick(); tick(); tick(); tick();
        imem_valid = 1'b1; imem_rdata = 32'h5A5A_0F0F;
        tick();
        chkb("tmo_win_ivalid", instr_valid, 1'b1);
        chkb("tmo_win_err", fetch_err, 1'b0);
        chk("tmo_win_instr", instr, 32'h5A5A_0F0F);
        $display("[TB] timeout and late response done");

        // Asynchronous reset mid-REQ at pc 0x10
        do_reset();
        imem_valid = 1'b1; imem_rdata = 32'h0;
        for (int k = 0; k < 8; k++) tick();
        imem_valid = 1'b0;
        tick();
        chk("mid_req_addr", imem_addr, 32'h10);
        #2 rst_n = 1'b0;
        imem_valid = 1'b1;
        #1;
        chk("async_pc", pc, 32'h0);
        chkb("async_req", imem_req, 1'b0);
        chk("async_pc_plus4", pc_plus4, 32'h4);
        tick();
        rst_n = 1'b1;
        tick();
        chkb("resume_req", imem_req, 1'b1);
        chk("resume_addr", imem_addr, 32'h0);
        $display("[TB] async reset mid-REQ done");

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            imem_valid   = ($urandom_range(0, 9) < 7);
            imem_rdata   = $urandom;
            stall        = ($urandom_range(0, 3) == 0);
            branch_taken = 1'($urandom_range(0, 1));
            jump         = ($urandom_range(0, 3) == 0);
            if (!rst_n) begin
                rst_n = 1'b1;
            end else if ((m_mode == M_DEAD && $urandom_range(0, 3) == 0) ||
                         $urandom_range(0, 99) == 0) begin
                #2 rst_n = 1'b0;
            end
        end
        $display("[TB] random traffic done");

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] SHALL be 0.
REQ-002 Parameter TIMEOUT, 16, maximum REQ cycles allowed without imem_valid; legal range 1..65535.
REQ-003 clk  in  1  single clock; all state changes on posedge clk.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 imem_req  out  1  fetch request to instruction memory.
REQ-006 imem_addr  out  32  byte address of the requested word; equals pc.
REQ-007 imem_valid  in  1  instruction memory returns imem_rdata this cycle.
REQ-008 imem_rdata  in  32  fetched instruction word.
REQ-009 stall  in  1  downstream (control/decode) not ready to consume instr.
REQ-010 branch_taken  in  1  downstream branch resolved taken (branch AND ALU zero/not-zero), sampled only at retire.
REQ-011 jump  in  1  downstream control jump, sampled only at retire.
REQ-012 instr  out  32  held instruction presented to control; instr[31:26] drives the opcode decode.
REQ-013 instr_valid  out  1  instr is valid and held.
REQ-014 pc  out  32  address of instr / current fetch address.
REQ-015 pc_plus4  out  32  pc + 4, modulo 2^32.
REQ-016 fetch_err  out  1  sticky timeout error.

Function
REQ-017 The FSM SHALL have states IDLE, REQ, HOLD and ERR, encoded internally.
REQ-018 IDLE SHALL go to REQ unconditionally on the first clock edge after rst_n deasserts.
REQ-019 In REQ, imem_req SHALL be 1 and imem_addr SHALL equal pc; in all other states imem_req SHALL be 0.
REQ-020 In REQ with imem_valid=1, the block SHALL latch instr<=imem_rdata and go to HOLD; instr_valid SHALL be 1 from the next cycle.
REQ-021 imem_valid outside REQ SHALL be ignored.
REQ-022 In HOLD with stall=1, the block SHALL hold state, and instr, pc and instr_valid SHALL remain stable.
REQ-023 In HOLD with stall=0 (retire), the block SHALL load pc<=next_pc, clear instr_valid and go to REQ; the new request SHALL be visible the next cycle.
REQ-024 next_pc for jump=1 SHALL be {pc_plus4[31:28], instr[25:0], 2'b00}; jump SHALL take priority over branch_taken.
REQ-025 next_pc for branch_taken=1 (and jump=0) SHALL be pc_plus4 + (sign_extend(instr[15:0]) << 2), with 32-bit wrap-around.
REQ-026 next_pc in all other cases SHALL be pc_plus4; pc+4 from 32'hFFFF_FFFC SHALL wrap to 0.
REQ-027 Minimum throughput SHALL be one instruction per 2 cycles with single-cycle memory response and no stall.
REQ-028 A wait counter SHALL clear on each entry to REQ and SHALL increment in each REQ cycle with imem_valid=0.
REQ-029 If imem_valid=0 on the TIMEOUT-th consecutive REQ cycle, the block SHALL go to ERR and set fetch_err=1.
REQ-030 imem_valid=1 in any REQ cycle, including the TIMEOUT-th, SHALL win over the timeout.
REQ-031 ERR SHALL be terminal until reset: imem_req=0, instr_valid=0, and pc held.
REQ-032 branch_taken and jump SHALL be ignored in every cycle except a HOLD retire cycle.

Reset
REQ-033 When rst_n=0, the block SHALL immediately (asynchronously) force state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, fetch_err=0 and the wait counter=0.
REQ-034 Reset asserted mid-REQ or mid-HOLD SHALL abandon the outstanding fetch; an imem_valid arriving after reset SHALL be ignored unless the block is in REQ.
REQ-035 pc_plus4 SHALL equal RESET_PC+4 during reset.

Verification
REQ-036 Reset then 1-cycle memory, stall=0, sequential code -> imem_addr 0x0, 0x4, 0x8 on successive requests; instr_valid pulses every 2nd cycle.
REQ-037 stall=1 for 3 cycles in HOLD -> instr, pc=0x4 and instr_valid=1 stable; imem_req=0 throughout; fetch at 0x8 one cycle after stall drops.
REQ-038 instr=32'h0800_0010 at pc 0x0, jump=1, branch_taken=1 at retire -> next imem_addr=0x40.
REQ-039 instr imm16=16'hFFFF at pc 0x8, branch_taken=1 -> next imem_addr=0x8; same case with branch_taken=0 -> 0xC.
REQ-040 TIMEOUT=4, imem_valid held 0 -> fetch_err=1 and imem_req=0 after 4 REQ cycles; rerun with imem_valid=1 on the 4th REQ cycle -> instr accepted and fetch_err=0.
REQ-041 rst_n pulsed low mid-REQ at pc 0x10 -> pc=RESET_PC and imem_req=0 in the same cycle (async); fetch resumes at RESET_PC.
